// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and payload types for the branch offset encoder.
//   IMM_W_DEFAULT : default width of the encoded branch immediate
//   PC_INC        : byte increment from a branch to its delay-slot successor
//   WORD_SHIFT    : byte-to-word shift applied to branch offsets
package mips_pkg;

    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned IMM_W_DEFAULT = 16;
    localparam int unsigned PC_INC        = 4;
    localparam int unsigned WORD_SHIFT    = 2;
    localparam int unsigned STAT_W        = 16;

    // Stage-2 payload: the sign-extended immediate plus its error flags.
    // The narrow imm field is the low IMM_W bits of signimm.
    typedef struct packed {
        logic [ADDR_W-1:0] signimm;
        logic              err_misalign;
        logic              err_range;
    } result_t;

    // Byte distance from the branch successor (pc + PC_INC) to target, mod 2^32.
    function automatic logic [ADDR_W-1:0] branch_diff(input logic [ADDR_W-1:0] pc,
                                                      input logic [ADDR_W-1:0] target);
        return target - (pc + ADDR_W'(PC_INC));
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/ready register slice.
//   clk, rst_n      : clock, asynchronous active-low reset (clears valid and data)
//   in_valid/in_data: upstream request and payload
//   in_ready_c      : slice can take a request (empty, or draining this cycle)
//   out_valid/out_data : registered result held until out_ready
//   out_ready       : downstream accepts the held result
module pipe_stage #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready_c,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Ready depends only on local state and downstream ready, never on in_valid.
    assign in_ready_c = !out_valid || out_ready;

    // Slice register: load whenever there is room, keep data stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready_c) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/branch_offset_encoder.sv
// branch_offset_encoder: inverse of the branch target adder. Given the branch
// pc and a desired target, produces imm with target = pc + 4 + (sext(imm) << 2).
// Two-stage valid/ready pipeline: stage 1 holds diff, stage 2 holds imm/flags.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : request handshake; pc, target are the request payload
//   out_valid, out_ready: result handshake
//   imm, signimm        : encoded field and its 32-bit sign extension (0 on error)
//   err_misalign        : diff not a multiple of 4
//   err_range           : word offset does not fit signed IMM_W
//   stat_ok, stat_err   : saturating result counters, only with
//                         `define BRANCH_OFFSET_ENCODER_STATS_EN
module branch_offset_encoder
    import mips_pkg::*;
#(
    parameter int unsigned IMM_W = IMM_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  imm,
    output logic [ADDR_W-1:0] signimm,
`ifdef BRANCH_OFFSET_ENCODER_STATS_EN
    output logic [STAT_W-1:0] stat_ok,
    output logic [STAT_W-1:0] stat_err,
`endif
    output logic              err_misalign,
    output logic              err_range
);

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_diff;
    logic              s2_ready_c;
    logic [ADDR_W-1:0] diff_c;
    logic [ADDR_W-1:0] word_off_c;
    logic [ADDR_W-IMM_W:0] word_hi_c;
    logic              fits_c;
    result_t           res_c;
    result_t           s2_res;

    assign diff_c = branch_diff(pc, target);

    // Stage 1: byte difference, wrap-around kept as a plain mod-2^32 value.
    pipe_stage #(
        .W (ADDR_W)
    ) u_stage1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready_c (in_ready),
        .in_data    (diff_c),
        .out_valid  (s1_valid),
        .out_ready  (s2_ready_c),
        .out_data   (s1_diff)
    );

    // Word offset fits signed IMM_W when every bit from IMM_W-1 upward matches.
    assign word_off_c = ADDR_W'($signed(s1_diff) >>> WORD_SHIFT);
    assign word_hi_c  = word_off_c[ADDR_W-1:IMM_W-1];
    assign fits_c     = (&word_hi_c) || !(|word_hi_c);

    // When in range, sext(imm) is exactly the word offset, so signimm needs no
    // separate extension step.
    always_comb begin
        res_c              = '0;
        res_c.err_misalign = (s1_diff[1:0] != 2'b00);
        res_c.err_range    = !fits_c;
        if (!res_c.err_misalign && !res_c.err_range) begin
            res_c.signimm = word_off_c;
        end
    end

    // Stage 2: encoded result and flags.
    pipe_stage #(
        .W ($bits(result_t))
    ) u_stage2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s1_valid),
        .in_ready_c (s2_ready_c),
        .in_data    (res_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (s2_res)
    );

    assign signimm      = s2_res.signimm;
    assign imm          = s2_res.signimm[IMM_W-1:0];
    assign err_misalign = s2_res.err_misalign;
    assign err_range    = s2_res.err_range;

`ifdef BRANCH_OFFSET_ENCODER_STATS_EN
    logic out_xfer_c;
    logic out_err_c;

    assign out_xfer_c = out_valid && out_ready;
    assign out_err_c  = s2_res.err_misalign || s2_res.err_range;

    // Saturating counters of delivered results, split by error status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ok  <= '0;
            stat_err <= '0;
        end else if (out_xfer_c) begin
            if (out_err_c) begin
                if (stat_err != '1) begin
                    stat_err <= stat_err + STAT_W'(1);
                end
            end else if (stat_ok != '1) begin
                stat_ok <= stat_ok + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_offset_encoder.sv
// tb_branch_offset_encoder: directed vector table plus stall-stream and
// reset-while-full sequences for branch_offset_encoder (IMM_W = 16).
module tb_branch_offset_encoder;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic [15:0] imm;
        logic [31:0] signimm;
        logic        mis;
        logic        rng;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc;
    logic [31:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm;
    logic [31:0] signimm;
    logic        err_misalign;
    logic        err_range;
`ifdef BRANCH_OFFSET_ENCODER_STATS_EN
    logic [15:0] stat_ok;
    logic [15:0] stat_err;
`endif

    int n_checks;
    int n_pass;

    vec_t vecs[9];

    branch_offset_encoder #(
        .IMM_W (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc           (pc),
        .target       (target),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .imm          (imm),
        .signimm      (signimm),
`ifdef BRANCH_OFFSET_ENCODER_STATS_EN
        .stat_ok      (stat_ok),
        .stat_err     (stat_err),
`endif
        .err_misalign (err_misalign),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_result(input string name, input vec_t v);
        chk({name, ".imm"},     32'(imm),          32'(v.imm));
        chk({name, ".signimm"}, signimm,           v.signimm);
        chk({name, ".mis"},     32'(err_misalign), 32'(v.mis));
        chk({name, ".rng"},     32'(err_range),    32'(v.rng));
    endtask

    // One request with out_ready high: accepted, empty after one edge, result after two.
    task automatic run_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        @(negedge clk);
        in_valid = 1'b1;
        pc       = vecs[i].pc;
        target   = vecs[i].target;
        #1;
        chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, ".lat1_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, ".lat2_valid"}, 32'(out_valid), 32'd1);
        chk_result(nm, vecs[i]);
    endtask

    initial begin
        int idx;
        int got;
        bit done;
        logic [31:0] held_signimm;
        logic        held_mis;
        logic        held_rng;
        int          order[4];

        n_checks = 0;
        n_pass   = 0;

        //           pc            target        imm      signimm       mis   rng
        vecs[0] = '{32'h00400000, 32'h00400010, 16'h0003, 32'h00000003, 1'b0, 1'b0};
        vecs[1] = '{32'h00400020, 32'h00400000, 16'hFFF7, 32'hFFFFFFF7, 1'b0, 1'b0};
        vecs[2] = '{32'h00000000, 32'h00020000, 16'h7FFF, 32'h00007FFF, 1'b0, 1'b0};
        vecs[3] = '{32'h00000000, 32'h00020004, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{32'h00400000, 32'h00400006, 16'h0000, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{32'hFFFFFFF8, 32'h00000004, 16'h0002, 32'h00000002, 1'b0, 1'b0};
        vecs[6] = '{32'h00020000, 32'h00000004, 16'h8000, 32'hFFFF8000, 1'b0, 1'b0};
        vecs[7] = '{32'h00020000, 32'h00000000, 16'h0000, 32'h00000000, 1'b0, 1'b1};
        vecs[8] = '{32'h00000000, 32'h00030001, 16'h0000, 32'h00000000, 1'b1, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        pc        = '0;
        target    = '0;
        #12;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.in_ready",  32'(in_ready),  32'd1);
        chk("rst.signimm",   signimm,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Stream of four requests with out_ready low for cycles 2..4.
        order[0] = 0; order[1] = 1; order[2] = 5; order[3] = 6;
        @(negedge clk);
        @(negedge clk);
        idx  = 0;
        got  = 0;
        done = 1'b0;
        held_signimm = '0;
        held_mis     = 1'b0;
        held_rng     = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            bit accept;
            out_ready = !(cyc >= 2 && cyc < 5);
            in_valid  = (idx < 4);
            pc        = (idx < 4) ? vecs[order[idx]].pc     : 32'd0;
            target    = (idx < 4) ? vecs[order[idx]].target : 32'd0;
            #1;
            if (cyc == 2) begin
                chk("stream.stall_valid",   32'(out_valid), 32'd1);
                chk("stream.in_ready_full", 32'(in_ready),  32'd0);
                held_signimm = signimm;
                held_mis     = err_misalign;
                held_rng     = err_range;
            end
            if (cyc == 3 || cyc == 4) begin
                chk("stream.stall_valid",   32'(out_valid),    32'd1);
                chk("stream.stall_signimm", signimm,           held_signimm);
                chk("stream.stall_flags",   32'({err_misalign, err_range}),
                    32'({held_mis, held_rng}));
            end
            if (out_valid && out_ready) begin
                chk_result($sformatf("stream%0d", got), vecs[order[got]]);
                got++;
                if (got == 4) done = 1'b1;
            end
            accept = in_valid && in_ready;
            @(posedge clk);
            if (accept) idx++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream.count", 32'(got), 32'd4);

        // Fill both stages under stall, then reset asynchronously mid-cycle.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc        = vecs[0].pc;
        target    = vecs[0].target;
        @(negedge clk);
        pc        = vecs[1].pc;
        target    = vecs[1].target;
        @(negedge clk);
        in_valid  = 1'b0;
        #1;
        chk("prerst.out_valid", 32'(out_valid), 32'd1);
        chk("prerst.in_ready",  32'(in_ready),  32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstfull.out_valid", 32'(out_valid), 32'd0);
        chk("rstfull.in_ready",  32'(in_ready),  32'd1);
        chk("rstfull.imm",       32'(imm),       32'd0);
        chk("rstfull.signimm",   signimm,        32'd0);
`ifdef BRANCH_OFFSET_ENCODER_STATS_EN
        chk("rstfull.stat_ok",  32'(stat_ok),  32'd0);
        chk("rstfull.stat_err", 32'(stat_err), 32'd0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("postrst.no_stale", 32'(out_valid), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
